switch_duty_conditioner: RTL

- Upstream stage of the PWM generator.
- Takes the raw, asynchronous 4-bit slide-switch bus and synchronises and debounces it as a whole bus.
- Clamps the debounced value to the legal duty range (0..MAX_CODE, tens of percent) and presents it as a stable duty code.
- Issues a one-cycle change strobe so the PWM block reloads its compare value only on a clean, committed change.

---
 rtl/switch_duty_conditioner.sv | 123 ++++++++++++
 1 files changed

// File: rtl/switch_duty_conditioner.sv
// switch_duty_conditioner: synchronises, debounces and clamps the raw
// slide-switch bus into a stable duty code for the PWM generator. It also
// issues a one-cycle strobe whenever the committed duty code changes.
module switch_duty_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_CODE        = 10,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] switch,
    output logic [3:0] duty_code,
    output logic       code_changed,
    output logic       clamped,
    output logic       settling
);

    typedef enum logic [1:0] {
        ST_STABLE = 2'd0,
        ST_CHECK  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       MAX_C    = 4'(MAX_CODE);

    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       committed_q, committed_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [3:0]       duty_q, duty_d;
    logic             changed_q, changed_d;
    logic             clamped_q, clamped_d;
    logic [3:0]       cand_sat;

    // Two-flop synchroniser. The bus is treated as one word, and the FSM
    // only ever looks at sync2.
    always_comb begin
        sync1_d = switch;
        sync2_d = sync1_q;
    end

    // State and data registers. Reset is synchronous and clears everything,
    // so any pending candidate is dropped without a strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            committed_q <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            state_q     <= ST_STABLE;
            duty_q      <= '0;
            changed_q   <= 1'b0;
            clamped_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            committed_q <= committed_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            duty_q      <= duty_d;
            changed_q   <= changed_d;
            clamped_q   <= clamped_d;
        end
    end

    // Next-state logic. In CHECK, a restart on a new bus value takes
    // priority over the commit, so the counter never runs past CNT_LAST.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_STABLE: begin
                if (sync2_q != committed_q) begin
                    state_d = ST_CHECK;
                    cand_d  = sync2_q;
                    cnt_d   = '0;
                end
            end
            ST_CHECK: begin
                if (sync2_q == committed_q) begin
                    state_d = ST_STABLE;
                end else if (sync2_q != cand_q) begin
                    cand_d = sync2_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COMMIT: state_d = ST_STABLE;
            default:   state_d = ST_STABLE;
        endcase
    end

    // Commit datapath. The clamped candidate is loaded only in COMMIT, and
    // the strobe fires only when the visible duty code actually changes.
    always_comb begin
        cand_sat    = (cand_q > MAX_C) ? MAX_C : cand_q;
        committed_d = committed_q;
        duty_d      = duty_q;
        clamped_d   = clamped_q;
        changed_d   = 1'b0;
        if (state_q == ST_COMMIT) begin
            committed_d = cand_q;
            duty_d      = cand_sat;
            clamped_d   = (cand_q > MAX_C);
            changed_d   = (cand_sat != duty_q);
        end
    end

    assign duty_code    = duty_q;
    assign code_changed = changed_q;
    assign clamped      = clamped_q;
    assign settling     = (state_q == ST_CHECK);

endmodule
